// File: rtl/vsm_pkg.sv
// Shared opcode constants, FSM state type, phase encoding and opcode class for the control sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a. The jump classes exist only when VSM_SEQ_JUMP_EN is defined.
package vsm_pkg;

    localparam logic [3:0] OPC_NOP  = 4'd0;
    localparam logic [3:0] OPC_ADD  = 4'd1;
    localparam logic [3:0] OPC_SUB  = 4'd2;
    localparam logic [3:0] OPC_OUT  = 4'd3;
    localparam logic [3:0] OPC_IN   = 4'd4;
    localparam logic [3:0] OPC_LOAD = 4'd5;
    localparam logic [3:0] OPC_JMP  = 4'd6;
    localparam logic [3:0] OPC_JZ   = 4'd7;

    localparam logic [1:0] PH_FETCH  = 2'd0;
    localparam logic [1:0] PH_DECODE = 2'd1;
    localparam logic [1:0] PH_EXEC1  = 2'd2;
    localparam logic [1:0] PH_EXEC2  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC1,
        ST_EXEC2,
        ST_WAIT_IN,
        ST_WAIT_OUT,
        ST_HALT
    } state_t;

    // One-hot opcode class; exactly one field is set for any opcode value.
    typedef struct packed {
        logic nop;
        logic add;
        logic sub;
        logic out;
        logic inp;
        logic load;
`ifdef VSM_SEQ_JUMP_EN
        logic jmp;
        logic jz;
`endif
        logic hlt;
        logic ill;
    } opc_class_t;

endpackage

// File: rtl/vsm_opcode_decode.sv
// Combinational opcode-register to one-hot class decoder (VSM_SEQ_JUMP_EN enables JMP/JZ classes).
// Latency: 0 cycles, pure combinational.
// Backpressure: none.
module vsm_opcode_decode
    import vsm_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic [OPC_W-1:0] opc,
    output opc_class_t       cls
);

    logic       upper_zero;
    logic [3:0] low;

    always_comb begin
        cls        = '0;
        upper_zero = ((opc >> 4) == '0);
        low        = opc[3:0];
        // HLT is all ones at any width, so it is checked before the upper-bit rule.
        if (&opc) begin
            cls.hlt = 1'b1;
        end else if (!upper_zero) begin
            cls.ill = 1'b1;
        end else begin
            case (low)
                OPC_NOP:  cls.nop  = 1'b1;
                OPC_ADD:  cls.add  = 1'b1;
                OPC_SUB:  cls.sub  = 1'b1;
                OPC_OUT:  cls.out  = 1'b1;
                OPC_IN:   cls.inp  = 1'b1;
                OPC_LOAD: cls.load = 1'b1;
`ifdef VSM_SEQ_JUMP_EN
                OPC_JMP:  cls.jmp  = 1'b1;
                OPC_JZ:   cls.jz   = 1'b1;
`endif
                default:  cls.ill  = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/vsm_control_sequencer.sv
// Microcoded control sequencer: FETCH/DECODE/EXEC FSM driving datapath strobes; VSM_SEQ_JUMP_EN adds JMP/JZ.
// Latency: 3 cycles per instruction, 4 for ADD/SUB, plus wait cycles for IN/OUT handshakes.
// Backpressure: stalls in WAIT_IN/WAIT_OUT until handshake or STALL_MAX cycles, then Timeout.
module vsm_control_sequencer
    import vsm_pkg::*;
#(
    parameter int OPC_W     = 4,
    parameter int STALL_MAX = 15
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             Run,
    input  logic [OPC_W-1:0] InstrIn,
    input  logic             AccZero,
    input  logic             InValid,
    output logic             InAck,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [1:0]       Phase,
    output logic             ReadMem,
    output logic             LoadInst,
    output logic             ProgCount,
    output logic             EnableInstr,
    output logic             LoadA,
    output logic             EnableA,
    output logic             LoadB,
    output logic             EnableAlu,
    output logic             AddSub,
    output logic             EnableIn,
    output logic             LoadOut,
    output logic             LoadPc,
    output logic             Halted,
    output logic             IllegalOp,
    output logic             Timeout
);

    // The counter only needs to reach STALL_MAX-1.
    localparam int CNT_W = (STALL_MAX > 1) ? $clog2(STALL_MAX) : 1;
    localparam logic [CNT_W-1:0] STALL_LAST = CNT_W'((STALL_MAX > 0) ? STALL_MAX - 1 : 0);

    state_t           state_q, state_d;
    logic [OPC_W-1:0] opc_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    opc_class_t       cls;
`ifdef VSM_SEQ_JUMP_EN
    logic             az_q;
`endif

    vsm_opcode_decode #(
        .OPC_W (OPC_W)
    ) u_decode (
        .opc (opc_q),
        .cls (cls)
    );

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            state_q <= ST_IDLE;
            opc_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`ifdef VSM_SEQ_JUMP_EN
            az_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            if (state_q == ST_FETCH) begin
                opc_q <= InstrIn;
            end
`ifdef VSM_SEQ_JUMP_EN
            // The accumulator is stable through DECODE, so JZ can use a registered flag.
            if (state_q == ST_DECODE) begin
                az_q <= AccZero;
            end
`endif
        end
    end

    assign Timeout = tmo_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        tmo_d       = 1'b0;
        Phase       = PH_FETCH;
        ReadMem     = 1'b0;
        LoadInst    = 1'b0;
        ProgCount   = 1'b0;
        EnableInstr = 1'b0;
        LoadA       = 1'b0;
        EnableA     = 1'b0;
        LoadB       = 1'b0;
        EnableAlu   = 1'b0;
        AddSub      = 1'b0;
        EnableIn    = 1'b0;
        LoadOut     = 1'b0;
        LoadPc      = 1'b0;
        InAck       = 1'b0;
        OutValid    = 1'b0;
        Halted      = 1'b0;
        IllegalOp   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (Run) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ReadMem  = 1'b1;
                LoadInst = 1'b1;
                state_d  = ST_DECODE;
            end
            ST_DECODE: begin
                Phase     = PH_DECODE;
                ProgCount = 1'b1;
                state_d   = ST_EXEC1;
            end
            ST_EXEC1: begin
                Phase   = PH_EXEC1;
                state_d = ST_FETCH;
                unique case (1'b1)
                    cls.nop: ;
                    cls.load: begin
                        EnableInstr = 1'b1;
                        LoadA       = 1'b1;
                    end
                    cls.add: begin
                        EnableInstr = 1'b1;
                        LoadB       = 1'b1;
                        state_d     = ST_EXEC2;
                    end
                    cls.sub: begin
                        EnableInstr = 1'b1;
                        LoadB       = 1'b1;
                        AddSub      = 1'b1;
                        state_d     = ST_EXEC2;
                    end
                    cls.out: begin
                        EnableA = 1'b1;
                        LoadOut = 1'b1;
                        state_d = ST_WAIT_OUT;
                    end
                    cls.inp: begin
                        // EnableIn is a pure state/opcode decode; only the capture follows InValid.
                        EnableIn = 1'b1;
                        LoadA    = InValid;
                        InAck    = InValid;
                        if (!InValid) state_d = ST_WAIT_IN;
                    end
`ifdef VSM_SEQ_JUMP_EN
                    cls.jmp: begin
                        EnableInstr = 1'b1;
                        LoadPc      = 1'b1;
                    end
                    cls.jz: begin
                        EnableInstr = az_q;
                        LoadPc      = az_q;
                    end
`endif
                    cls.hlt: state_d = ST_HALT;
                    cls.ill: IllegalOp = 1'b1;
                    default: ;
                endcase
            end
            ST_EXEC2: begin
                Phase     = PH_EXEC2;
                EnableAlu = 1'b1;
                LoadA     = 1'b1;
                AddSub    = cls.sub;
                state_d   = ST_FETCH;
            end
            ST_WAIT_IN, ST_WAIT_OUT: begin
                Phase = PH_EXEC2;
                if (state_q == ST_WAIT_IN) begin
                    EnableIn = 1'b1;
                    LoadA    = InValid;
                    InAck    = InValid;
                end else begin
                    OutValid = 1'b1;
                end
                if ((state_q == ST_WAIT_IN) ? InValid : OutReady) begin
                    state_d = ST_FETCH;
                end else if (STALL_MAX == 0) begin
                    cnt_d = '0;
                end else if (cnt_q == STALL_LAST) begin
                    // Transfer abandoned; Timeout shows during the following FETCH.
                    state_d = ST_FETCH;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HALT: begin
                Halted = 1'b1;
                if (Run) state_d = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_vsm_control_sequencer.sv
// Directed bench for vsm_control_sequencer: per-cycle output snapshots queued as stimulus is driven.
module tb_vsm_control_sequencer;

    logic       Clock = 1'b0;
    logic       ResetN, Run, AccZero, InValid, OutReady;
    logic [3:0] InstrIn;
    logic       InAck, OutValid, ReadMem, LoadInst, ProgCount, EnableInstr, LoadA, EnableA;
    logic       LoadB, EnableAlu, AddSub, EnableIn, LoadOut, LoadPc, Halted, IllegalOp, Timeout;
    logic [1:0] Phase;

    vsm_control_sequencer #(.OPC_W(4), .STALL_MAX(15)) dut (
        .Clock(Clock), .ResetN(ResetN), .Run(Run), .InstrIn(InstrIn), .AccZero(AccZero),
        .InValid(InValid), .InAck(InAck), .OutValid(OutValid), .OutReady(OutReady),
        .Phase(Phase), .ReadMem(ReadMem), .LoadInst(LoadInst), .ProgCount(ProgCount),
        .EnableInstr(EnableInstr), .LoadA(LoadA), .EnableA(EnableA), .LoadB(LoadB),
        .EnableAlu(EnableAlu), .AddSub(AddSub), .EnableIn(EnableIn), .LoadOut(LoadOut),
        .LoadPc(LoadPc), .Halted(Halted), .IllegalOp(IllegalOp), .Timeout(Timeout)
    );

    always #5 Clock = ~Clock;

    localparam logic [16:0] M_RM = 17'h10000, M_LI = 17'h08000, M_PC = 17'h04000;
    localparam logic [16:0] M_EI = 17'h02000, M_LA = 17'h01000, M_EA = 17'h00800;
    localparam logic [16:0] M_LB = 17'h00400, M_EU = 17'h00200, M_AS = 17'h00100;
    localparam logic [16:0] M_EN = 17'h00080, M_LO = 17'h00040, M_LP = 17'h00020;
    localparam logic [16:0] M_IA = 17'h00010, M_OV = 17'h00008, M_HA = 17'h00004;
    localparam logic [16:0] M_IL = 17'h00002, M_TO = 17'h00001;

    logic [18:0] outs;
    assign outs = {Phase, ReadMem, LoadInst, ProgCount, EnableInstr, LoadA, EnableA, LoadB,
                   EnableAlu, AddSub, EnableIn, LoadOut, LoadPc, InAck, OutValid, Halted,
                   IllegalOp, Timeout};

    logic [18:0] sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic push(input logic [1:0] ph, input logic [16:0] m);
        sb.push_back({ph, m});
    endtask

    task automatic push_fd(input logic [16:0] fetch_extra);
        push(2'd0, M_RM | M_LI | fetch_extra);
        push(2'd1, M_PC);
    endtask

    task automatic chk(input string tag);
        logic [18:0] exp;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: observed %05h, scoreboard empty", tag, outs);
        end else begin
            exp = sb.pop_front();
            assert (outs === exp) else begin
                miscompares++;
                $error("FAIL %s: observed %05h expected %05h", tag, outs, exp);
            end
        end
    endtask

    task automatic cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge Clock);
            chk(tag);
            @(posedge Clock);
            #1;
        end
    endtask

    initial begin
        ResetN = 1'b1; Run = 1'b0; InstrIn = 4'd0; AccZero = 1'b0;
        InValid = 1'b0; OutReady = 1'b0;
        #2 ResetN = 1'b0;
        #6;
        push(2'd0, 17'd0); chk("reset");
        #4 ResetN = 1'b1;
        @(posedge Clock); #1;

        // Idle without Run
        push(2'd0, 17'd0); push(2'd0, 17'd0);
        cycles(2, "idle_no_run");

        // LOAD: Phase 0,1,2,0
        Run = 1'b1; InstrIn = 4'd5;
        push(2'd0, 17'd0);
        cycles(1, "run_sample");
        Run = 1'b0;
        push_fd(17'd0); push(2'd2, M_EI | M_LA);
        cycles(3, "load");

        // SUB
        InstrIn = 4'd2;
        push_fd(17'd0); push(2'd2, M_EI | M_LB | M_AS); push(2'd3, M_EU | M_LA | M_AS);
        cycles(4, "sub");

        // IN, InValid low for 3 wait cycles then high
        InstrIn = 4'd4;
        push_fd(17'd0); push(2'd2, M_EN);
        for (int i = 0; i < 3; i++) push(2'd3, M_EN);
        cycles(6, "in_wait");
        InValid = 1'b1;
        push(2'd3, M_EN | M_LA | M_IA);
        cycles(1, "in_handshake");
        InValid = 1'b0;

        // OUT with OutReady never high: 15 wait cycles, then Timeout in the next FETCH
        InstrIn = 4'd3;
        push_fd(17'd0); push(2'd2, M_EA | M_LO);
        for (int i = 0; i < 15; i++) push(2'd3, M_OV);
        cycles(18, "out_stall");

        // JZ with AccZero=1 (fetch carries the Timeout pulse)
        InstrIn = 4'd7; AccZero = 1'b1;
        push_fd(M_TO);
`ifdef VSM_SEQ_JUMP_EN
        push(2'd2, M_EI | M_LP);
`else
        push(2'd2, M_IL);
`endif
        cycles(3, "jz_taken");

        // JZ with AccZero=0
        AccZero = 1'b0;
        push_fd(17'd0);
`ifdef VSM_SEQ_JUMP_EN
        push(2'd2, 17'd0);
`else
        push(2'd2, M_IL);
`endif
        cycles(3, "jz_not_taken");

        // JMP
        InstrIn = 4'd6;
        push_fd(17'd0);
`ifdef VSM_SEQ_JUMP_EN
        push(2'd2, M_EI | M_LP);
`else
        push(2'd2, M_IL);
`endif
        cycles(3, "jmp");

        // Unlisted opcode behaves as NOP with IllegalOp, then a real NOP
        InstrIn = 4'd8;
        push_fd(17'd0); push(2'd2, M_IL);
        cycles(3, "illegal_8");
        InstrIn = 4'd0;
        push_fd(17'd0); push(2'd2, 17'd0);
        cycles(3, "nop");

        // OUT accepted after two wait cycles; OutValid low in the following FETCH
        InstrIn = 4'd3;
        push_fd(17'd0); push(2'd2, M_EA | M_LO); push(2'd3, M_OV); push(2'd3, M_OV);
        cycles(5, "out_wait");
        OutReady = 1'b1;
        push(2'd3, M_OV);
        cycles(1, "out_handshake");
        OutReady = 1'b0;

        // IN with InValid already high: handshake in EXEC1, no ack before it
        InstrIn = 4'd4; InValid = 1'b1;
        push_fd(17'd0); push(2'd2, M_EN | M_LA | M_IA);
        cycles(3, "in_direct");
        InValid = 1'b0;

        // HLT, Run ignored while running, Halted held
        InstrIn = 4'hF; Run = 1'b0;
        push_fd(17'd0); push(2'd2, 17'd0);
        for (int i = 0; i < 3; i++) push(2'd0, M_HA);
        cycles(6, "halt");
        Run = 1'b1;
        push(2'd0, M_HA);
        cycles(1, "halt_run");
        Run = 1'b0;

        // ADD, then async reset in the middle of EXEC2
        InstrIn = 4'd1;
        push_fd(17'd0); push(2'd2, M_EI | M_LB);
        cycles(3, "add");
        #2;
        push(2'd3, M_EU | M_LA); chk("add_exec2");
        ResetN = 1'b0;
        #1;
        push(2'd0, 17'd0); chk("async_reset");
        @(negedge Clock);
        push(2'd0, 17'd0); chk("reset_hold");
        ResetN = 1'b1;
        @(posedge Clock); #1;

        // Back in IDLE: nothing until Run, FETCH in the cycle after Run is sampled
        push(2'd0, 17'd0); push(2'd0, 17'd0);
        cycles(2, "idle_after_reset");
        Run = 1'b1;
        push(2'd0, 17'd0);
        cycles(1, "rerun_sample");
        Run = 1'b0;
        push(2'd0, M_RM | M_LI);
        cycles(1, "rerun_fetch");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
